mem_arbiter: RTL and testbench

// - Shares the single 256-bit Data_Memory port between instruction cache (port 0) and dcache_controller (port 1).
// - Sits between both cache controllers and Data_Memory.
// - Sequences one memory transaction at a time and routes the ack back to the owning requester.
// - Requesters see the same enable/write/addr/data/ack handshake that Data_Memory itself presents.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port Data_Memory arbiter.
// MEM_ARB_RR_EN (optional macro) selects round-robin tie-breaking; see mem_arb_pick.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t GNT0 = 2'd1;
    localparam arb_state_t GNT1 = 2'd2;

    // One-hot owner view of the state; IDLE (or any stray code) owns nothing.
    function automatic logic [1:0] state_to_gnt(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GNT0) g = 2'b01;
        if (s == GNT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between icache (port 0) and dcache (port 1).
// MEM_ARB_RR_EN defined: ties alternate away from last_gnt; otherwise dcache wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic any,
    output logic win
);

    always_comb begin
        any = req0 | req1;
        win = PORT_I;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            win = ~last_gnt;
`else
            win = PORT_D;
`endif
        end else if (req1) begin
            win = PORT_D;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores history; the register is still kept in the top.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache (port 0) and dcache (port 1) onto the single Data_Memory port.
// Optional macro MEM_ARB_RR_EN switches tie-breaking from fixed (dcache) to round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic [1:0]        gnt_o
);

    arb_state_t state;
    logic       last_gnt;
    logic       pick_any;
    logic       pick_win;

    mem_arb_pick u_pick (
        .req0     (p0_enable_i),
        .req1     (p1_enable_i),
        .last_gnt (last_gnt),
        .any      (pick_any),
        .win      (pick_win)
    );

    // A grant is only released by mem_ack_i, never by the requester dropping
    // enable, so Data_Memory always completes what it started.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= PORT_I;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) state <= (pick_win == PORT_D) ? GNT1 : GNT0;
                end
                GNT0: begin
                    if (mem_ack_i) begin
                        state    <= IDLE;
                        last_gnt <= PORT_I;
                    end
                end
                GNT1: begin
                    if (mem_ack_i) begin
                        state    <= IDLE;
                        last_gnt <= PORT_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side mux: address and data follow the owner live (nothing is latched).
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            GNT0: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p0_write_i;
                mem_addr_o   = p0_addr_i;
                mem_data_o   = p0_data_i;
            end
            GNT1: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
            end
            default: ;
        endcase
    end

    // A stray ack while IDLE (e.g. left over from before a reset) reaches nobody.
    always_comb begin
        p0_ack_o = mem_ack_i & (state == GNT0);
        p1_ack_o = mem_ack_i & (state == GNT1);
    end

    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;
    assign gnt_o     = state_to_gnt(state);

    ack_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(p0_ack_o && p1_ack_o));
    gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle owner model plus literal checks on key scenarios.
// Honours MEM_ARB_RR_EN the same way the design does.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk;
    logic          rst;
    logic          p0_en, p0_wr, p1_en, p1_wr;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ack;
    logic [1:0]    gnt;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    mem_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p0_enable_i  (p0_en),
        .p0_write_i   (p0_wr),
        .p0_addr_i    (p0_addr),
        .p0_data_i    (p0_wdata),
        .p0_ack_o     (p0_ack),
        .p0_data_o    (p0_rdata),
        .p1_enable_i  (p1_en),
        .p1_write_i   (p1_wr),
        .p1_addr_i    (p1_addr),
        .p1_data_i    (p1_wdata),
        .p1_ack_o     (p1_ack),
        .p1_data_o    (p1_rdata),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack),
        .gnt_o        (gnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner model: who holds the memory this cycle (-1 = nobody) and who was served last.
    int   m_owner = -1;
    logic m_last  = 1'b0;

    function automatic int tie_winner(input logic last);
`ifdef MEM_ARB_RR_EN
        return last ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 1'b0;
        end else if (m_owner < 0) begin
            if (p0_en && p1_en) m_owner = tie_winner(m_last);
            else if (p1_en)     m_owner = 1;
            else if (p0_en)     m_owner = 0;
        end else if (mem_ack) begin
            m_last  = (m_owner == 1);
            m_owner = -1;
        end
    end

    // scoreboard compare: every mid-cycle, all outputs against the owner model
    always @(negedge clk) begin
        if (check_en) begin
            logic [1:0]    e_gnt;
            logic          e_wr;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_data;
            e_gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
            e_wr   = (m_owner == 0) ? p0_wr   : (m_owner == 1) ? p1_wr   : 1'b0;
            e_addr = (m_owner == 0) ? p0_addr : (m_owner == 1) ? p1_addr : '0;
            e_data = (m_owner == 0) ? p0_wdata : (m_owner == 1) ? p1_wdata : '0;
            chk("gnt",        DW'(gnt),      DW'(e_gnt));
            chk("mem_enable", DW'(mem_en),   DW'(m_owner >= 0));
            chk("mem_write",  DW'(mem_wr),   DW'(e_wr));
            chk("mem_addr",   DW'(mem_addr), DW'(e_addr));
            chk("mem_data",   mem_wdata,     e_data);
            chk("p0_ack",     DW'(p0_ack),   DW'(mem_ack && m_owner == 0));
            chk("p1_ack",     DW'(p1_ack),   DW'(mem_ack && m_owner == 1));
            if (p0_ack) chk("p0_data", p0_rdata, mem_rdata);
            if (p1_ack) chk("p1_data", p1_rdata, mem_rdata);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output logic [1:0] g);
        int n;
        n = 0;
        while (gnt == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        g = gnt;
        if (n >= budget) chk("grant_timeout", DW'(1), DW'(0));
    endtask

    task automatic pulse_ack(input logic [DW-1:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
    endtask

    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    logic [1:0] g;
    logic [DW-1:0] pat;

    initial begin
        rst = 1'b0;
        p0_en = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
        p1_en = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        #2 rst = 1'b1;
        #20 rst = 1'b0;
        check_en = 1;
        #1;
        chk("reset_gnt", DW'(gnt), DW'(2'b00));
        chk("reset_en",  DW'(mem_en), DW'(0));

        // reset mid-GNT1, then a stale ack must reach nobody
        p1_en = 1; p1_addr = 32'h200;
        tick();
        chk("t1_gnt1", DW'(gnt), DW'(2'b10));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_gnt",  DW'(gnt), DW'(2'b00));
        chk("t1_rst_en",   DW'(mem_en), DW'(0));
        chk("t1_rst_addr", DW'(mem_addr), DW'(0));
        p1_en = 0;
        tick();
        rst = 1'b0;
        tick();
        mem_ack = 1'b1;
        #1;
        chk("t1_stale_ack0", DW'(p0_ack), DW'(0));
        chk("t1_stale_ack1", DW'(p1_ack), DW'(0));
        tick();
        mem_ack = 1'b0;

        // single read on port 0, ack after 10 cycles
        p0_en = 1; p0_wr = 0; p0_addr = 32'h40;
        @(negedge clk); #1;
        chk("t2_not_yet", DW'(mem_en), DW'(0));
        tick();
        chk("t2_en",   DW'(mem_en), DW'(1));
        chk("t2_addr", DW'(mem_addr), DW'(32'h40));
        repeat (9) tick();
        pat = {8{32'hDEADBEEF}};
        mem_ack = 1'b1; mem_rdata = pat;
        #1;
        chk("t2_ack0",  DW'(p0_ack), DW'(1));
        chk("t2_data0", p0_rdata, pat);
        chk("t2_ack1",  DW'(p1_ack), DW'(0));
        tick();
        mem_ack = 1'b0; p0_en = 0;
        chk("t2_idle", DW'(gnt), DW'(2'b00));
        tick();

        // simultaneous requests after reset: port 1 first, one IDLE, then port 0
        do_reset();
        p0_en = 1; p0_addr = 32'h100;
        p1_en = 1; p1_addr = 32'h80;
        tick();
        chk("t3_first", DW'(gnt), DW'(2'b10));
        repeat (2) tick();
        pulse_ack('0);
        p1_en = 0;
        chk("t3_gap", DW'(gnt), DW'(2'b00));
        tick();
        chk("t3_second", DW'(gnt), DW'(2'b01));
        tick();
        pulse_ack('0);
        p0_en = 0;
        tick();

        // both held for four transactions
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        p0_en = 1; p1_en = 1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(10, g);
            seq[i] = g;
            repeat (2) tick();
            pulse_ack('0);
        end
        p0_en = 0; p1_en = 0;
        for (int i = 0; i < 4; i++) chk($sformatf("t4_grant%0d", i), DW'(seq[i]), DW'(exp_seq[i]));
        tick();

        // write routing: p1 write first, then p0 read
        do_reset();
        p1_en = 1; p1_wr = 1; p1_addr = 32'h80; p1_wdata = {32{8'hA5}};
        p0_en = 1; p0_wr = 0; p0_addr = 32'h100; p0_wdata = 256'h123;
        tick();
        chk("t5_w_wr",   DW'(mem_wr), DW'(1));
        chk("t5_w_addr", DW'(mem_addr), DW'(32'h80));
        chk("t5_w_data", mem_wdata, {32{8'hA5}});
        tick();
        pulse_ack('0);
        p1_en = 0; p1_wr = 0;
        tick();
        chk("t5_r_gnt",  DW'(gnt), DW'(2'b01));
        chk("t5_r_wr",   DW'(mem_wr), DW'(0));
        chk("t5_r_addr", DW'(mem_addr), DW'(32'h100));
        pulse_ack({64{4'h7}});
        p0_en = 0;
        tick();

        // requester drops enable while granted
        p0_en = 1; p0_addr = 32'h300;
        tick();
        repeat (2) tick();
        p0_en = 0;
        #1;
        chk("t6_held_en",  DW'(mem_en), DW'(1));
        chk("t6_held_gnt", DW'(gnt), DW'(2'b01));
        repeat (3) tick();
        mem_ack = 1'b1; mem_rdata = {32{8'h3C}};
        #1;
        chk("t6_ack0", DW'(p0_ack), DW'(1));
        tick();
        mem_ack = 1'b0;
        chk("t6_idle", DW'(gnt), DW'(2'b00));
        repeat (2) tick();

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
